// File: rtl/mmio_console_tx.sv
// Memory-mapped console transmitter: CPU stores to TXDATA fill a FIFO that drains as a byte stream.
// Optional CONSOLE_SIM_PRINT_EN adds a simulation-only character echo on each pop.
module mmio_console_tx #(
  parameter logic [31:0] BASE_ADDR     = 32'h1000_0000,
  parameter int          DEPTH         = 16,
  parameter bit          STALL_ON_FULL = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mmio_sel,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        out_valid,
  output logic [7:0]  out_data,
  input  logic        out_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ACK  = 1'b1;

  logic [0:0]    state_reg, state_next;
  logic [7:0]    fifo_mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [LW-1:0] level_reg, level_next;
  logic [7:0]    ovf_cnt_reg;
  logic          mem_ready_reg;
  logic [31:0]   mem_rdata_reg, rdata_next;

  logic [1:0]  reg_idx;
  logic        is_write, fifo_full, fifo_empty, tx_write, stall, accept;
  logic        push, pop, drop, flush, clr_ovf;
  logic [31:0] status_word;
  logic        unused_bits;

  assign mmio_sel   = mem_valid && (mem_addr[31:4] == BASE_ADDR[31:4]);
  assign reg_idx    = mem_addr[3:2];
  assign is_write   = |mem_wstrb;
  assign fifo_full  = (level_reg == FULL_LEVEL);
  assign fifo_empty = (level_reg == '0);

  // Full is judged on the current level only, so a same-cycle pop never frees a stalled write early.
  assign tx_write = mmio_sel && is_write && (reg_idx == 2'd0);
  assign stall    = tx_write && fifo_full && STALL_ON_FULL;
  assign accept   = (state_reg == ST_IDLE) && mmio_sel && !mem_ready_reg && !stall;

  assign push    = accept && tx_write && mem_wstrb[0] && !fifo_full;
  assign drop    = accept && tx_write && mem_wstrb[0] && fifo_full;
  assign flush   = accept && is_write && (reg_idx == 2'd2) && mem_wdata[0];
  assign clr_ovf = accept && is_write && (reg_idx == 2'd2) && mem_wdata[1];
  assign pop     = out_valid && out_ready;

  assign status_word = {ovf_cnt_reg, 6'b0, fifo_full, fifo_empty, 16'(level_reg)};
  assign unused_bits = ^{mem_addr[1:0], mem_wdata[31:8]};

  always_comb begin
    state_next = state_reg;
    rdata_next = 32'h0;
    if (state_reg == ST_ACK) begin
      state_next = ST_IDLE;
    end else if (accept) begin
      state_next = ST_ACK;
      if (!is_write && (reg_idx == 2'd1)) rdata_next = status_word;
    end
  end

  always_comb begin
    level_next = level_reg;
    if (push && !pop)      level_next = level_reg + LW'(1);
    else if (pop && !push) level_next = level_reg - LW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      mem_ready_reg <= 1'b0;
      mem_rdata_reg <= 32'h0;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      level_reg     <= '0;
      ovf_cnt_reg   <= 8'h0;
    end else begin
      state_reg     <= state_next;
      mem_ready_reg <= (state_next == ST_ACK);
      mem_rdata_reg <= rdata_next;
      // A flush discards everything, including a byte popped on the same edge.
      if (flush) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        level_reg  <= '0;
      end else begin
        if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
        if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
        level_reg <= level_next;
      end
      if (clr_ovf)                         ovf_cnt_reg <= 8'h0;
      else if (drop && ovf_cnt_reg != 8'hFF) ovf_cnt_reg <= ovf_cnt_reg + 8'h1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= mem_wdata[7:0];
  end

  assign mem_ready = mem_ready_reg;
  assign mem_rdata = mem_rdata_reg;
  assign out_valid = !fifo_empty;
  // Gate the head so an empty FIFO presents zero rather than stale or uninitialised storage.
  assign out_data  = fifo_empty ? 8'h00 : fifo_mem[rd_ptr_reg];

`ifdef CONSOLE_SIM_PRINT_EN
  always @(posedge clk) begin
    if (!reset && pop) $write("%c", out_data);
  end
`else
`endif

endmodule

// File: tb/tb_mmio_console_tx.sv
// Directed bench for mmio_console_tx: unit 0 stalls when full, unit 1 drops and counts overflows.
module tb_mmio_console_tx;

  localparam logic [31:0] TX = 32'h1000_0000;
  localparam logic [31:0] ST = 32'h1000_0004;
  localparam logic [31:0] CT = 32'h1000_0008;
  localparam logic [31:0] RS = 32'h1000_000C;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [3:0]  wstrb = 4'h0;
  logic valid0 = 1'b0, valid1 = 1'b0;
  logic ordy0 = 1'b0, ordy1 = 1'b0;
  logic sel0, ready0, ov0, sel1, ready1, ov1;
  logic [31:0] rdata0, rdata1;
  logic [7:0] od0, od1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mmio_console_tx #(.BASE_ADDR(32'h1000_0000), .DEPTH(16), .STALL_ON_FULL(1'b1)) dut (
    .clk(clk), .reset(reset), .mem_valid(valid0), .mem_addr(addr), .mem_wdata(wdata),
    .mem_wstrb(wstrb), .mmio_sel(sel0), .mem_ready(ready0), .mem_rdata(rdata0),
    .out_valid(ov0), .out_data(od0), .out_ready(ordy0)
  );

  mmio_console_tx #(.BASE_ADDR(32'h1000_0000), .DEPTH(16), .STALL_ON_FULL(1'b0)) dut_nf (
    .clk(clk), .reset(reset), .mem_valid(valid1), .mem_addr(addr), .mem_wdata(wdata),
    .mem_wstrb(wstrb), .mmio_sel(sel1), .mem_ready(ready1), .mem_rdata(rdata1),
    .out_valid(ov1), .out_data(od1), .out_ready(ordy1)
  );

  // One bus access on unit u; lat is cycles from request to mem_ready, -1 on timeout.
  task automatic bus(input int u, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, input int max_wait,
                     output logic [31:0] rd, output int lat);
    @(posedge clk); #1;
    addr = a; wdata = d; wstrb = s;
    if (u == 0) valid0 = 1'b1; else valid1 = 1'b1;
    lat = -1;
    rd = 32'h0;
    for (int k = 1; k <= max_wait; k++) begin
      @(posedge clk); #1;
      if (((u == 0) ? ready0 : ready1) === 1'b1) begin
        lat = k;
        rd = (u == 0) ? rdata0 : rdata1;
        break;
      end
    end
    valid0 = 1'b0;
    valid1 = 1'b0;
  endtask

  task automatic wr(input int u, input logic [31:0] a, input logic [31:0] d, output int lat);
    logic [31:0] r;
    bus(u, a, d, 4'hF, 20, r, lat);
  endtask

  task automatic rd(input int u, input logic [31:0] a, output logic [31:0] r);
    int l;
    bus(u, a, 32'h0, 4'h0, 20, r, l);
  endtask

  task automatic test_reset;
    logic [31:0] r;
    reset = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checks++; if (ready0 !== 1'b0) begin errors++; $display("FAIL reset_ready got %0b want 0", ready0); end
    checks++; if (rdata0 !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", rdata0); end
    checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", ov0); end
    checks++; if (od0 !== 8'h00) begin errors++; $display("FAIL reset_out_data got %h want 00", od0); end
    checks++; if (ov1 !== 1'b0 || ready1 !== 1'b0) begin errors++; $display("FAIL reset_unit1 got ov=%0b rdy=%0b want 0 0", ov1, ready1); end
    reset = 1'b0;
    rd(0, ST, r);
    checks++; if (r !== 32'h0001_0000) begin errors++; $display("FAIL reset_status got %h want 00010000", r); end
  endtask

  task automatic test_hello;
    int lat;
    logic [31:0] r;
    logic seen;
    ordy0 = 1'b1;
    wr(0, TX, 32'h48, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL hello_lat_H got %0d want 1", lat); end
    checks++; if (ov0 !== 1'b1 || od0 !== 8'h48) begin errors++; $display("FAIL hello_head_H got v=%0b d=%h want 1 48", ov0, od0); end
    @(posedge clk); #1;
    checks++; if (ready0 !== 1'b0 || rdata0 !== 32'h0) begin errors++; $display("FAIL hello_one_cycle_ack got rdy=%0b rdata=%h want 0 0", ready0, rdata0); end
    wr(0, TX, 32'h69, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL hello_lat_i got %0d want 1", lat); end
    checks++; if (ov0 !== 1'b1 || od0 !== 8'h69) begin errors++; $display("FAIL hello_head_i got v=%0b d=%h want 1 69", ov0, od0); end
    rd(0, ST, r);
    checks++; if (r !== 32'h0001_0000) begin errors++; $display("FAIL hello_status got %h want 00010000", r); end
    rd(0, TX, r);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL txdata_read got %h want 0", r); end
    rd(0, RS, r);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL reserved_read got %h want 0", r); end
    // Out-of-window request: no select, never acknowledged.
    @(posedge clk); #1;
    addr = 32'h2000_0000; wstrb = 4'h0; valid0 = 1'b1;
    #1;
    checks++; if (sel0 !== 1'b0) begin errors++; $display("FAIL sel_outside got %0b want 0", sel0); end
    seen = 1'b0;
    repeat (3) begin @(posedge clk); #1; if (ready0 !== 1'b0) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL outside_no_ack got %0b want 0", seen); end
    addr = ST;
    #1;
    checks++; if (sel0 !== 1'b1) begin errors++; $display("FAIL sel_inside got %0b want 1", sel0); end
    valid0 = 1'b0;
    ordy0 = 1'b0;
  endtask

  task automatic test_fill_stall;
    int lat, bad;
    logic [31:0] r;
    logic [7:0] exp;
    logic stalled;
    ordy0 = 1'b0;
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      wr(0, TX, 32'h30 + i, lat);
      if (lat != 1) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL fill_lat got %0d slow writes want 0", bad); end
    rd(0, ST, r);
    checks++; if (r !== 32'h0002_0010) begin errors++; $display("FAIL full_status got %h want 00020010", r); end
    checks++; if (od0 !== 8'h30) begin errors++; $display("FAIL full_head got %h want 30", od0); end
    @(posedge clk); #1;
    addr = TX; wdata = 32'h40; wstrb = 4'hF; valid0 = 1'b1;
    stalled = 1'b1;
    repeat (5) begin @(posedge clk); #1; if (ready0 !== 1'b0) stalled = 1'b0; end
    checks++; if (stalled !== 1'b1) begin errors++; $display("FAIL stall_hold got %0b want 1", stalled); end
    ordy0 = 1'b1;
    @(posedge clk); #1;
    ordy0 = 1'b0;
    checks++; if (ready0 !== 1'b0) begin errors++; $display("FAIL stall_pop_edge got %0b want 0", ready0); end
    @(posedge clk); #1;
    checks++; if (ready0 !== 1'b1) begin errors++; $display("FAIL stall_release got %0b want 1", ready0); end
    valid0 = 1'b0;
    checks++; if (od0 !== 8'h31) begin errors++; $display("FAIL stall_head got %h want 31", od0); end
    rd(0, ST, r);
    checks++; if (r !== 32'h0002_0010) begin errors++; $display("FAIL refill_status got %h want 00020010", r); end
    bad = 0;
    ordy0 = 1'b1;
    for (int k = 0; k < 16; k++) begin
      exp = (k < 15) ? 8'(8'h31 + k) : 8'h40;
      if (ov0 !== 1'b1 || od0 !== exp) bad++;
      @(posedge clk); #1;
    end
    ordy0 = 1'b0;
    checks++; if (bad !== 0) begin errors++; $display("FAIL drain_order got %0d bad bytes want 0", bad); end
    checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL drain_empty got %0b want 0", ov0); end
  endtask

  task automatic test_overflow;
    int lat, bad;
    logic [31:0] r;
    ordy1 = 1'b0;
    for (int i = 0; i < 16; i++) wr(1, TX, 32'h50 + i, lat);
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      wr(1, TX, 32'hE0 + i, lat);
      if (lat != 1) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL drop_ack got %0d unacked want 0", bad); end
    rd(1, ST, r);
    checks++; if (r !== 32'h0302_0010) begin errors++; $display("FAIL ovf3_status got %h want 03020010", r); end
    checks++; if (od1 !== 8'h50) begin errors++; $display("FAIL ovf_head got %h want 50", od1); end
    for (int i = 0; i < 297; i++) wr(1, TX, 32'hF0, lat);
    rd(1, ST, r);
    checks++; if (r !== 32'hFF02_0010) begin errors++; $display("FAIL ovf_saturate got %h want ff020010", r); end
    wr(1, CT, 32'h2, lat);
    rd(1, ST, r);
    checks++; if (r !== 32'h0002_0010) begin errors++; $display("FAIL ovf_clear got %h want 00020010", r); end
    checks++; if (od1 !== 8'h50) begin errors++; $display("FAIL ovf_clear_head got %h want 50", od1); end
  endtask

  task automatic test_flush;
    int lat, bad;
    logic [31:0] r, r2;
    ordy0 = 1'b0;
    for (int i = 0; i < 8; i++) wr(0, TX, 32'h60 + i, lat);
    rd(0, ST, r);
    checks++; if (r !== 32'h0000_0008) begin errors++; $display("FAIL partial_status got %h want 00000008", r); end
    wr(0, CT, 32'h1, lat);
    checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL flush_out_valid got %0b want 0", ov0); end
    rd(0, ST, r);
    checks++; if (r !== 32'h0001_0000) begin errors++; $display("FAIL flush_status got %h want 00010000", r); end
    bus(0, TX, 32'hEE, 4'b1110, 20, r2, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL nostrb_ack got %0d want 1", lat); end
    rd(0, ST, r);
    checks++; if (r !== 32'h0001_0000) begin errors++; $display("FAIL nostrb_status got %h want 00010000", r); end
    wr(0, TX, 32'hA1, lat);
    wr(0, TX, 32'hA2, lat);
    wr(0, TX, 32'hA3, lat);
    bad = 0;
    ordy0 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (ov0 !== 1'b1 || od0 !== 8'(8'hA1 + k)) bad++;
      @(posedge clk); #1;
    end
    ordy0 = 1'b0;
    checks++; if (bad !== 0) begin errors++; $display("FAIL post_flush_order got %0d bad bytes want 0", bad); end
    checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL post_flush_empty got %0b want 0", ov0); end
  endtask

  task automatic test_reset_stall;
    int lat;
    logic [31:0] r;
    logic quiet;
    ordy0 = 1'b0;
    for (int i = 0; i < 16; i++) wr(0, TX, 32'h70 + i, lat);
    @(posedge clk); #1;
    addr = TX; wdata = 32'h7F; wstrb = 4'hF; valid0 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    quiet = 1'b1;
    repeat (3) begin @(posedge clk); #1; if (ready0 !== 1'b0) quiet = 1'b0; end
    checks++; if (quiet !== 1'b1) begin errors++; $display("FAIL rst_stall_no_ack got %0b want 1", quiet); end
    checks++; if (ov0 !== 1'b0 || od0 !== 8'h00) begin errors++; $display("FAIL rst_stall_out got v=%0b d=%h want 0 00", ov0, od0); end
    valid0 = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
    checks++; if (ready0 !== 1'b0) begin errors++; $display("FAIL rst_stall_after got %0b want 0", ready0); end
    rd(0, ST, r);
    checks++; if (r !== 32'h0001_0000) begin errors++; $display("FAIL rst_stall_status got %h want 00010000", r); end
  endtask

  initial begin
    test_reset();
    test_hello();
    test_fill_stall();
    test_overflow();
    test_flush();
    test_reset_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
